// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman processing element: FSM state encoding,
// traceback codes and saturating arithmetic on unsigned biased scores.
package sw_pkg;

  // Helpers work at this width. Callers zero-extend their operands and pass their
  // real score width, which must be less than MAX_W.
  localparam int MAX_W = 32;

  typedef logic [MAX_W-1:0] wide_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    TB_ZERO = 2'd0,
    TB_DIAG = 2'd1,
    TB_E    = 2'd2,
    TB_F    = 2'd3
  } tb_code_t;

  // a + b, clipped at 2^w - 1
  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned w);
    logic [MAX_W:0] sum;
    logic [MAX_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[MAX_W-1:0] : sum[MAX_W-1:0];
  endfunction

  // a - b, clipped at 0
  function automatic wide_t sat_sub(input wide_t a, input wide_t b);
    return (a > b) ? (a - b) : '0;
  endfunction

  // On a tie the first argument is returned
  function automatic wide_t sat_max(input wide_t a, input wide_t b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/sw_cell_comb.sv
// Combinational E/F/H recurrence of one Smith-Waterman cell, plus the traceback
// code when SW_TRACEBACK_EN is defined.
module sw_cell_comb
  import sw_pkg::*;
#(
  parameter int SCORE_WIDTH = 12,
  parameter int SYM_WIDTH   = 2,
  parameter int LOCAL       = 1
) (
  input  logic [SYM_WIDTH-1:0]   data,
  input  logic [SYM_WIDTH-1:0]   query,
  input  logic [SCORE_WIDTH-1:0] diag,
  input  logic [SCORE_WIDTH-1:0] h_left,
  input  logic [SCORE_WIDTH-1:0] e_left,
  input  logic [SCORE_WIDTH-1:0] h_up,
  input  logic [SCORE_WIDTH-1:0] f_up,
  input  logic [SCORE_WIDTH-1:0] match,
  input  logic [SCORE_WIDTH-1:0] mismatch,
  input  logic [SCORE_WIDTH-1:0] gap_open,
  input  logic [SCORE_WIDTH-1:0] gap_extend,
  output logic [SCORE_WIDTH-1:0] h,
  output logic [SCORE_WIDTH-1:0] e,
`ifdef SW_TRACEBACK_EN
  output logic [1:0]             tb,
`endif
  output logic [SCORE_WIDTH-1:0] f
);

  typedef logic [SCORE_WIDTH-1:0] score_t;

  localparam score_t ZERO = score_t'(1) << (SCORE_WIDTH - 1);

  function automatic score_t add_s(input score_t a, input score_t b);
    return score_t'(sat_add(wide_t'(a), wide_t'(b), SCORE_WIDTH));
  endfunction

  function automatic score_t sub_s(input score_t a, input score_t b);
    return score_t'(sat_sub(wide_t'(a), wide_t'(b)));
  endfunction

  function automatic score_t max_s(input score_t a, input score_t b);
    return score_t'(sat_max(wide_t'(a), wide_t'(b)));
  endfunction

  score_t sub;
  score_t best;
  logic   clamp;

  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    sub   = (data == query) ? add_s(diag, match) : sub_s(diag, mismatch);
    e     = max_s(sub_s(h_left, gap_open), sub_s(e_left, gap_extend));
    f     = max_s(sub_s(h_up, gap_open), sub_s(f_up, gap_extend));
    best  = max_s(sub, max_s(e, f));
    clamp = (LOCAL != 0) && (best < ZERO);
    h     = clamp ? ZERO : best;
  end

`ifdef SW_TRACEBACK_EN
  // Ties resolve diag first, then E, then F.
  always_comb begin
    if (clamp)              tb = TB_ZERO;
    else if (best == sub)   tb = TB_DIAG;
    else if (best == e)     tb = TB_E;
    else                    tb = TB_F;
  end
`endif

endmodule

// File: rtl/sw_pe_gen.sv
// Smith-Waterman systolic processing element: one query symbol, latency-1 cell,
// running-maximum chain and sequence FSM. Define SW_TRACEBACK_EN to add tb_out.
module sw_pe_gen
  import sw_pkg::*;
#(
  parameter int SCORE_WIDTH = 12,
  parameter int SYM_WIDTH   = 2,
  parameter int POS_WIDTH   = 16,
  parameter int LOCAL       = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   q_load,
  input  logic [SYM_WIDTH-1:0]   q_in,
  input  logic                   en_in,
  input  logic                   sof_in,
  input  logic                   eof_in,
  input  logic [SYM_WIDTH-1:0]   data_in,
  input  logic [SCORE_WIDTH-1:0] H_in,
  input  logic [SCORE_WIDTH-1:0] E_in,
  input  logic [SCORE_WIDTH-1:0] High_in,
  input  logic [POS_WIDTH-1:0]   Pos_in,
  input  logic [SCORE_WIDTH-1:0] match,
  input  logic [SCORE_WIDTH-1:0] mismatch,
  input  logic [SCORE_WIDTH-1:0] gap_open,
  input  logic [SCORE_WIDTH-1:0] gap_extend,
  output logic                   en_out,
  output logic                   sof_out,
  output logic                   eof_out,
  output logic [SYM_WIDTH-1:0]   data_out,
  output logic [SCORE_WIDTH-1:0] H_out,
  output logic [SCORE_WIDTH-1:0] E_out,
  output logic [SCORE_WIDTH-1:0] High_out,
  output logic [POS_WIDTH-1:0]   Pos_out,
`ifdef SW_TRACEBACK_EN
  output logic [1:0]             tb_out,
`endif
  output logic                   vld
);

  typedef logic [SCORE_WIDTH-1:0] score_t;
  typedef logic [POS_WIDTH-1:0]   pos_t;

  localparam score_t ZERO = score_t'(1) << (SCORE_WIDTH - 1);

  state_t               state;
  state_t               state_nxt;
  logic                 accept;
  logic                 fin;
  logic [SYM_WIDTH-1:0] query;

  score_t diag, hup, fup, own_max;
  pos_t   own_pos, cnt;

  score_t diag_cur, hup_cur, fup_cur, own_cur, own_nxt;
  pos_t   cnt_cur, cnt_inc, own_pos_cur, own_pos_nxt;
  score_t h, e, f;
  logic   left_win;

`ifdef SW_TRACEBACK_EN
  logic [1:0] tb;
`endif

  // ---------------- sequence FSM ----------------
  // fin marks that the eof beat was accepted on the previous edge; vld then follows
  // one cycle after that beat's outputs appear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (en_in && sof_in) state_nxt = S_RUN;
      S_RUN:   if (fin && !(en_in && sof_in)) state_nxt = S_DONE;
      S_DONE:  state_nxt = (en_in && sof_in) ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A sof beat is always taken (start or restart); other beats only mid-sequence.
  always_comb begin
    accept = en_in && (sof_in || (state == S_RUN && !fin));
    vld    = (state == S_DONE);
  end

  // ---------------- cell inputs and maximum tracking ----------------
  always_comb begin
    diag_cur    = sof_in ? ZERO : diag;
    hup_cur     = sof_in ? ZERO : hup;
    fup_cur     = sof_in ? ZERO : fup;
    cnt_cur     = sof_in ? '0 : cnt;
    own_cur     = sof_in ? ZERO : own_max;
    own_pos_cur = sof_in ? '0 : own_pos;
    cnt_inc     = (cnt_cur == '1) ? cnt_cur : cnt_cur + pos_t'(1);
    own_nxt     = (h > own_cur) ? h : own_cur;
    own_pos_nxt = (h > own_cur) ? cnt_cur : own_pos_cur;
    left_win    = (High_in >= own_nxt);
  end

  sw_cell_comb #(
    .SCORE_WIDTH (SCORE_WIDTH),
    .SYM_WIDTH   (SYM_WIDTH),
    .LOCAL       (LOCAL)
  ) u_cell (
    .data       (data_in),
    .query      (query),
    .diag       (diag_cur),
    .h_left     (H_in),
    .e_left     (E_in),
    .h_up       (hup_cur),
    .f_up       (fup_cur),
    .match      (match),
    .mismatch   (mismatch),
    .gap_open   (gap_open),
    .gap_extend (gap_extend),
    .h          (h),
    .e          (e),
`ifdef SW_TRACEBACK_EN
    .tb         (tb),
`endif
    .f          (f)
  );

  // ---------------- registered datapath ----------------
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_out   <= 1'b0;
      sof_out  <= 1'b0;
      eof_out  <= 1'b0;
      data_out <= '0;
      H_out    <= ZERO;
      E_out    <= ZERO;
      High_out <= ZERO;
      Pos_out  <= '0;
      diag     <= ZERO;
      hup      <= ZERO;
      fup      <= ZERO;
      own_max  <= ZERO;
      own_pos  <= '0;
      cnt      <= '0;
      fin      <= 1'b0;
      query    <= '0;
`ifdef SW_TRACEBACK_EN
      tb_out   <= TB_ZERO;
`endif
    end else begin
      en_out <= accept;
      fin    <= accept && eof_in;
      if (q_load && state == S_IDLE) query <= q_in;
      if (accept) begin
        sof_out  <= sof_in;
        eof_out  <= eof_in;
        data_out <= data_in;
        H_out    <= h;
        E_out    <= e;
        diag     <= H_in;
        hup      <= h;
        fup      <= f;
        cnt      <= cnt_inc;
        own_max  <= own_nxt;
        own_pos  <= own_pos_nxt;
        High_out <= left_win ? High_in : own_nxt;
        Pos_out  <= left_win ? Pos_in : own_pos_nxt;
`ifdef SW_TRACEBACK_EN
        tb_out   <= tb;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sw_pe_gen.sv
// Directed bench for sw_pe_gen: a LOCAL=1 and a LOCAL=0 instance share all inputs;
// expected scores are hand-derived for match=2, mismatch=1, gap_open=3, gap_extend=1.
module tb_sw_pe_gen;

  localparam int SW = 12;
  localparam int YW = 2;
  localparam int PW = 16;
  localparam logic [YW-1:0] SYM_A = 2'd0;
  localparam logic [YW-1:0] SYM_C = 2'd1;
  localparam logic [YW-1:0] SYM_G = 2'd2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          q_load = 1'b0;
  logic [YW-1:0] q_in = '0;
  logic          en_in = 1'b0, sof_in = 1'b0, eof_in = 1'b0;
  logic [YW-1:0] data_in = '0;
  logic [SW-1:0] H_in = 12'd2048, E_in = 12'd2048, High_in = 12'd2048;
  logic [PW-1:0] Pos_in = '0;
  logic [SW-1:0] match = 12'd2, mismatch = 12'd1, gap_open = 12'd3, gap_extend = 12'd1;

  logic          en_out, sof_out, eof_out, vld;
  logic [YW-1:0] data_out;
  logic [SW-1:0] H_out, E_out, High_out;
  logic [PW-1:0] Pos_out;

  logic          en0, sof0, eof0, vld0;
  logic [YW-1:0] data0;
  logic [SW-1:0] h0, e0, high0;
  logic [PW-1:0] pos0;

`ifdef SW_TRACEBACK_EN
  logic [1:0] tb_out, tb0;
`endif

  int total = 0;
  int bad = 0;
  int vld_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (vld) vld_cnt++;

  sw_pe_gen #(.SCORE_WIDTH(SW), .SYM_WIDTH(YW), .POS_WIDTH(PW), .LOCAL(1)) u_dut (
    .clk(clk), .rst(rst), .q_load(q_load), .q_in(q_in),
    .en_in(en_in), .sof_in(sof_in), .eof_in(eof_in), .data_in(data_in),
    .H_in(H_in), .E_in(E_in), .High_in(High_in), .Pos_in(Pos_in),
    .match(match), .mismatch(mismatch), .gap_open(gap_open), .gap_extend(gap_extend),
    .en_out(en_out), .sof_out(sof_out), .eof_out(eof_out), .data_out(data_out),
    .H_out(H_out), .E_out(E_out), .High_out(High_out), .Pos_out(Pos_out),
`ifdef SW_TRACEBACK_EN
    .tb_out(tb_out),
`endif
    .vld(vld)
  );

  sw_pe_gen #(.SCORE_WIDTH(SW), .SYM_WIDTH(YW), .POS_WIDTH(PW), .LOCAL(0)) u_dut0 (
    .clk(clk), .rst(rst), .q_load(q_load), .q_in(q_in),
    .en_in(en_in), .sof_in(sof_in), .eof_in(eof_in), .data_in(data_in),
    .H_in(H_in), .E_in(E_in), .High_in(High_in), .Pos_in(Pos_in),
    .match(match), .mismatch(mismatch), .gap_open(gap_open), .gap_extend(gap_extend),
    .en_out(en0), .sof_out(sof0), .eof_out(eof0), .data_out(data0),
    .H_out(h0), .E_out(e0), .High_out(high0), .Pos_out(pos0),
`ifdef SW_TRACEBACK_EN
    .tb_out(tb0),
`endif
    .vld(vld0)
  );

  // One clock: inputs change on the falling edge, outputs are read 1 ns after the rising edge.
  task automatic beat(input logic en, input logic sof, input logic eof, input logic [YW-1:0] d);
    @(negedge clk);
    en_in = en; sof_in = sof; eof_in = eof; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic load_query(input logic [YW-1:0] q);
    @(negedge clk);
    en_in = 1'b0; sof_in = 1'b0; eof_in = 1'b0; q_load = 1'b1; q_in = q;
    @(posedge clk);
    #1 q_load = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    total++; if (H_out !== 12'd2048) begin bad++; $display("FAIL reset_h got=%0d want=2048", H_out); end
    total++; if (E_out !== 12'd2048) begin bad++; $display("FAIL reset_e got=%0d want=2048", E_out); end
    total++; if (High_out !== 12'd2048) begin bad++; $display("FAIL reset_high got=%0d want=2048", High_out); end
    total++; if ({en_out, sof_out, eof_out, vld} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", {en_out, sof_out, eof_out, vld}); end
    total++; if (Pos_out !== 16'd0) begin bad++; $display("FAIL reset_pos got=%0d want=0", Pos_out); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_match_run;
    load_query(SYM_A);
    beat(1'b1, 1'b1, 1'b0, SYM_A);
    total++; if (H_out !== 12'd2050 || en_out !== 1'b1) begin bad++; $display("FAIL aaa_b0 h=%0d en=%b want h=2050 en=1", H_out, en_out); end
    total++; if (E_out !== 12'd2047) begin bad++; $display("FAIL aaa_e got=%0d want=2047", E_out); end
    beat(1'b1, 1'b0, 1'b0, SYM_A);
    total++; if (H_out !== 12'd2050) begin bad++; $display("FAIL aaa_b1 h got=%0d want=2050", H_out); end
    beat(1'b1, 1'b0, 1'b1, SYM_A);
    total++; if (H_out !== 12'd2050 || eof_out !== 1'b1) begin bad++; $display("FAIL aaa_b2 h=%0d eof=%b want h=2050 eof=1", H_out, eof_out); end
    total++; if (High_out !== 12'd2050 || Pos_out !== 16'd0) begin bad++; $display("FAIL aaa_high high=%0d pos=%0d want 2050/0", High_out, Pos_out); end
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL aaa_vld_early got=%b want=0", vld); end
    beat(1'b0, 1'b0, 1'b0, SYM_A);
    total++; if (vld !== 1'b1 || en_out !== 1'b0) begin bad++; $display("FAIL aaa_vld vld=%b en=%b want vld=1 en=0", vld, en_out); end
    beat(1'b0, 1'b0, 1'b0, SYM_A);
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL aaa_vld_pulse got=%b want=0", vld); end
  endtask

  task automatic test_mismatch;
    beat(1'b1, 1'b1, 1'b1, SYM_G);
    total++; if (H_out !== 12'd2048) begin bad++; $display("FAIL mis_local h got=%0d want=2048", H_out); end
    total++; if (h0 !== 12'd2047) begin bad++; $display("FAIL mis_global h got=%0d want=2047", h0); end
`ifdef SW_TRACEBACK_EN
    total++; if (tb_out !== 2'd0) begin bad++; $display("FAIL mis_tb got=%0d want=0", tb_out); end
    total++; if (tb0 !== 2'd1) begin bad++; $display("FAIL mis_tb_global got=%0d want=1", tb0); end
`endif
    beat(1'b0, 1'b0, 1'b0, SYM_A);
    beat(1'b0, 1'b0, 1'b0, SYM_A);
  endtask

  task automatic test_saturation;
    match = 12'd4095;
    beat(1'b1, 1'b1, 1'b1, SYM_A);
    total++; if (H_out !== 12'd4095 || h0 !== 12'd4095) begin bad++; $display("FAIL sat_h got=%0d/%0d want=4095", H_out, h0); end
    total++; if (High_out !== 12'd4095) begin bad++; $display("FAIL sat_high got=%0d want=4095", High_out); end
    match = 12'd2;
    beat(1'b0, 1'b0, 1'b0, SYM_A);
    beat(1'b0, 1'b0, 1'b0, SYM_A);
  endtask

  task automatic test_bubble;
    int start;
    start = vld_cnt;
    beat(1'b1, 1'b1, 1'b0, SYM_A);
    beat(1'b1, 1'b0, 1'b0, SYM_A);
    beat(1'b0, 1'b0, 1'b0, SYM_A);
    total++; if (en_out !== 1'b0 || H_out !== 12'd2050) begin bad++; $display("FAIL bub_hold en=%b h=%0d want en=0 h=2050", en_out, H_out); end
    beat(1'b1, 1'b0, 1'b0, SYM_A);
    total++; if (en_out !== 1'b1) begin bad++; $display("FAIL bub_resume en got=%b want=1", en_out); end
    beat(1'b1, 1'b0, 1'b1, SYM_A);
    total++; if (H_out !== 12'd2050 || E_out !== 12'd2047) begin bad++; $display("FAIL bub_final h=%0d e=%0d want 2050/2047", H_out, E_out); end
    total++; if (High_out !== 12'd2050 || Pos_out !== 16'd0) begin bad++; $display("FAIL bub_high high=%0d pos=%0d want 2050/0", High_out, Pos_out); end
    beat(1'b0, 1'b0, 1'b0, SYM_A);
    beat(1'b0, 1'b0, 1'b0, SYM_A);
    total++; if (vld_cnt - start !== 1) begin bad++; $display("FAIL bub_vld_count got=%0d want=1", vld_cnt - start); end
  endtask

  task automatic test_restart;
    int start;
    start = vld_cnt;
    beat(1'b1, 1'b1, 1'b0, SYM_A);
    q_load = 1'b1; q_in = SYM_G;
    beat(1'b1, 1'b0, 1'b0, SYM_A);
    q_load = 1'b0;
    beat(1'b1, 1'b1, 1'b0, SYM_G);
    total++; if (H_out !== 12'd2048) begin bad++; $display("FAIL rst_seq_g h got=%0d want=2048", H_out); end
    beat(1'b1, 1'b0, 1'b0, SYM_A);
    total++; if (H_out !== 12'd2050) begin bad++; $display("FAIL rst_seq_a h got=%0d want=2050", H_out); end
    beat(1'b1, 1'b0, 1'b1, SYM_A);
    total++; if (High_out !== 12'd2050 || Pos_out !== 16'd1) begin bad++; $display("FAIL restart_pos high=%0d pos=%0d want 2050/1", High_out, Pos_out); end
    total++; if (vld_cnt - start !== 0) begin bad++; $display("FAIL restart_early_vld got=%0d want=0", vld_cnt - start); end
    beat(1'b0, 1'b0, 1'b0, SYM_A);
    beat(1'b0, 1'b0, 1'b0, SYM_A);
    total++; if (vld_cnt - start !== 1) begin bad++; $display("FAIL restart_vld_count got=%0d want=1", vld_cnt - start); end
  endtask

  task automatic test_reset_mid;
    int start;
    load_query(SYM_C);
    start = vld_cnt;
    beat(1'b1, 1'b1, 1'b0, SYM_C);
    total++; if (H_out !== 12'd2050 || data_out !== SYM_C) begin bad++; $display("FAIL rmid_pre h=%0d d=%0d want 2050/1", H_out, data_out); end
    @(negedge clk);
    en_in = 1'b1; sof_in = 1'b0; eof_in = 1'b0; data_in = SYM_C; rst = 1'b1;
    #1;
    total++; if (H_out !== 12'd2048 || E_out !== 12'd2048 || High_out !== 12'd2048) begin bad++; $display("FAIL rmid_scores h=%0d e=%0d high=%0d want 2048", H_out, E_out, High_out); end
    total++; if (data_out !== 2'd0 || en_out !== 1'b0 || Pos_out !== 16'd0) begin bad++; $display("FAIL rmid_ctrl d=%0d en=%b pos=%0d want 0", data_out, en_out, Pos_out); end
    @(negedge clk);
    rst = 1'b0;
    beat(1'b1, 1'b0, 1'b1, SYM_C);
    total++; if (en_out !== 1'b0 || H_out !== 12'd2048) begin bad++; $display("FAIL rmid_drop en=%b h=%0d want en=0 h=2048", en_out, H_out); end
    beat(1'b0, 1'b0, 1'b0, SYM_A);
    beat(1'b0, 1'b0, 1'b0, SYM_A);
    beat(1'b0, 1'b0, 1'b0, SYM_A);
    total++; if (vld_cnt - start !== 0) begin bad++; $display("FAIL rmid_vld got=%0d want=0", vld_cnt - start); end
  endtask

  initial begin
    test_reset();
    test_match_run();
    test_mismatch();
    test_saturation();
    test_bubble();
    test_restart();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
